// File: rtl/cache_line_ctrl_if.sv
// Bus bundle for cache_line_ctrl: CPU word port, physical-memory line port,
// and the external line data array. The controller uses the slave view; the
// surrounding system (CPU, memory, data array) uses the master view.
interface cache_line_ctrl_if;
    // CPU side
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    // Physical memory side
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    // External line data array
    logic [2:0]   array_set;
    logic         array_write;
    logic [127:0] array_datain;
    logic [127:0] array_dataout;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output array_set, array_write, array_datain,
        input  array_dataout
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  array_set, array_write, array_datain,
        output array_dataout
    );
endinterface

// File: rtl/cache_line_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 controller: 8 sets, 128-bit
// lines, 16-bit CPU words. Tag/valid/dirty live here; line data lives in an
// external array driven through the bus interface.
// Optional hit/miss counters are built when CACHE_LINE_CTRL_STATS_EN is defined.
module cache_line_ctrl #(
    parameter int LINE_W = 128,
    parameter int TAG_W  = 9
) (
    input  logic clk,
    input  logic reset,
    cache_line_ctrl_if.slave bus
`ifdef CACHE_LINE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t             state_q, state_d;
    logic [7:0]         valid_q, valid_d;
    logic [7:0]         dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q [8];
    logic               tag_we;

    logic [2:0]         index;
    logic [TAG_W-1:0]   tag_in;
    logic [2:0]         word;
    logic               req;
    logic               hit;
    logic               resp;
    logic               array_we;
    logic [LINE_W-1:0]  merged_line;
    logic               unused_addr_bit;

    assign index   = bus.mem_address[6:4];
    assign tag_in  = bus.mem_address[15:7];
    assign word    = bus.mem_address[3:1];
    assign req     = bus.mem_read | bus.mem_write;
    assign hit     = valid_q[index] && (tag_q[index] == tag_in);
    // Byte address bit 0 does not select anything inside a 16-bit word.
    assign unused_addr_bit = bus.mem_address[0];

    assign bus.array_set   = index;
    assign bus.mem_rdata   = bus.array_dataout[{word, 4'b0000} +: 16];
    assign bus.mem_resp    = resp;
    assign bus.array_write = array_we;

    // Splice the CPU word's enabled byte lanes into the current line.
    always_comb begin
        merged_line = bus.array_dataout;
        if (bus.mem_byte_enable[0])
            merged_line[{word, 4'b0000} +: 8] = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1])
            merged_line[{word, 4'b1000} +: 8] = bus.mem_wdata[15:8];
    end

    // Next-state and output decode for the lookup / writeback / fill sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_we           = 1'b0;
        resp             = 1'b0;
        array_we         = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
        bus.pmem_wdata   = bus.array_dataout;
        bus.array_datain = merged_line;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        resp = 1'b1;
                        if (bus.mem_write) begin
                            array_we       = 1'b1;
                            dirty_d[index] = 1'b1;
                        end
                    end else begin
                        state_d = dirty_q[index] ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[index], index, 4'b0000};
                if (bus.pmem_resp) begin
                    dirty_d[index] = 1'b0;
                    state_d        = FILL;
                end
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    array_we         = 1'b1;
                    bus.array_datain = bus.pmem_rdata;
                    valid_d[index]   = 1'b1;
                    dirty_d[index]   = 1'b0;
                    tag_we           = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A response or array write must never escape while reset is being sampled.
        if (reset) begin
            resp     = 1'b0;
            array_we = 1'b0;
        end
    end

    // State, valid and dirty registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag store load on fill completion.
    always_ff @(posedge clk) begin
        // NOTE: the tag store is a plain memory with no reset; valid bits guard it.
        if (!reset && tag_we)
            tag_q[index] <= tag_in;
    end

`ifdef CACHE_LINE_CTRL_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic        in_miss_q;
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    // A hit only counts if the request never left IDLE.
    assign hit_evt  = (state_q == IDLE) && req && hit && !in_miss_q;
    assign miss_evt = (state_q == IDLE) && req && !hit;

    // Saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_miss_q    <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (miss_evt)
                in_miss_q <= 1'b1;
            else if (resp)
                in_miss_q <= 1'b0;
            if (hit_evt && hit_count_q != 16'hFFFF)
                hit_count_q <= hit_count_q + 16'd1;
            if (miss_evt && miss_count_q != 16'hFFFF)
                miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
